viterbi_decoder: RTL and testbench

Fixed-point, log-domain Viterbi decoder for a discrete hidden Markov model with I hidden states and K observation symbols. It consumes a streamed observation sequence of up to N symbols, one per cycle. It runs add-compare-select over all states in parallel, then traces back to produce the most likely state path. It sits as the top-level accelerator block, with HMM parameters driven as parallel arrays by the surrounding system.

---
 rtl/viterbi_decoder_if.sv | 36 +++
 rtl/viterbi_decoder.sv | 164 ++++++++++++++++
 tb/tb_viterbi_decoder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/viterbi_decoder_if.sv
// Bus bundle for viterbi_decoder.
//   start/length      : run request and requested sequence length
//   obs_in/obs_valid  : streamed observation symbols, one per cycle
//   logC/logA/logB    : HMM log-domain parameters, held stable during a run
//   path/done         : decoded state sequence and result-valid flag
// master drives the request side; slave is the decoder.
interface viterbi_decoder_if #(
  parameter int I = 3,
  parameter int K = 3,
  parameter int N = 5,
  parameter int W = 20
);
  localparam int SW = (I > 1) ? $clog2(I) : 1;
  localparam int OW = (K > 1) ? $clog2(K) : 1;
  localparam int LW = $clog2(N + 1);

  logic                start;
  logic [LW-1:0]       length;
  logic [OW-1:0]       obs_in;
  logic                obs_valid;
  logic signed [W-1:0] logC [I];
  logic signed [W-1:0] logA [I][I];
  logic signed [W-1:0] logB [I][K];
  logic [SW-1:0]       path [N];
  logic                done;

  modport master (
    output start, length, obs_in, obs_valid, logC, logA, logB,
    input  path, done
  );

  modport slave (
    input  start, length, obs_in, obs_valid, logC, logA, logB,
    output path, done
  );
endinterface

// File: rtl/viterbi_decoder.sv
// Log-domain Viterbi decoder for an I-state, K-symbol HMM.
// Consumes up to N observations (one per cycle), runs add-compare-select
// over all states in parallel, then traces back one state per cycle.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : viterbi_decoder_if.slave (start/length, obs stream, HMM
//          parameters in; registered path/done out)
module viterbi_decoder #(
  parameter int I = 3,
  parameter int K = 3,
  parameter int N = 5,
  parameter int W = 20
) (
  input logic               clk,
  input logic               rst,
  viterbi_decoder_if.slave  bus
);
  localparam int SW = (I > 1) ? $clog2(I) : 1;
  localparam int LW = $clog2(N + 1);
  localparam int AW = W + $clog2(2 * N + 1);

  typedef enum logic [1:0] {IDLE, RUN, TRACE, DONE} state_t;

  state_t               state_q, state_d;
  logic [LW-1:0]        len_q, len_d;
  logic [LW-1:0]        t_q, t_d;
  logic [SW-1:0]        s_q, s_d;
  logic                 done_q, done_d;
  logic signed [AW-1:0] delta_q [I];
  logic signed [AW-1:0] delta_d [I];
  logic [SW-1:0]        bp_q [N][I];
  logic [SW-1:0]        bp_d [N][I];
  logic [SW-1:0]        path_q [N];
  logic [SW-1:0]        path_d [N];

  logic signed [AW-1:0] acs_delta [I];
  logic [SW-1:0]        acs_bp [I];
  logic [SW-1:0]        best_s;
  logic [LW-1:0]        len_clamp;
  logic [LW-1:0]        trace_idx;
  logic [SW-1:0]        trace_s;

  function automatic logic signed [AW-1:0] sext(input logic signed [W-1:0] v);
    return {{(AW - W){v[W-1]}}, v};
  endfunction

  // Add-compare-select for every destination state; strict '>' keeps the
  // lowest predecessor index on ties. At t = 0 the initial scores replace
  // the transition term.
  always_comb begin
    logic signed [AW-1:0] best;
    logic signed [AW-1:0] cand;
    for (int unsigned j = 0; j < I; j++) begin
      best      = delta_q[0] + sext(bus.logA[0][j]);
      acs_bp[j] = '0;
      for (int unsigned i = 1; i < I; i++) begin
        cand = delta_q[i] + sext(bus.logA[i][j]);
        if (cand > best) begin
          best      = cand;
          acs_bp[j] = SW'(i);
        end
      end
      if (t_q == '0) begin
        best = sext(bus.logC[j]);
      end
      acs_delta[j] = best + sext(bus.logB[j][bus.obs_in]);
    end
  end

  // Final argmax over delta, lowest index on ties.
  always_comb begin
    logic signed [AW-1:0] top;
    top    = delta_q[0];
    best_s = '0;
    for (int unsigned i = 1; i < I; i++) begin
      if (delta_q[i] > top) begin
        top    = delta_q[i];
        best_s = SW'(i);
      end
    end
  end

  assign len_clamp = (bus.length > LW'(N)) ? LW'(N) : bus.length;

  // On TRACE entry t_q == len_q, so every trace cycle writes path[t_q-1]:
  // the first from the argmax, later ones by following bp[t_q][s_q].
  assign trace_idx = t_q - LW'(1);
  assign trace_s   = (t_q == len_q) ? best_s : bp_q[t_q][s_q];

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    t_d     = t_q;
    s_d     = s_q;
    done_d  = 1'b0;
    delta_d = delta_q;
    bp_d    = bp_q;
    path_d  = path_q;
    unique case (state_q)
      IDLE, DONE: begin
        done_d = (state_q == DONE);
        if (bus.start) begin
          len_d  = len_clamp;
          t_d    = '0;
          done_d = 1'b0;
          for (int unsigned n = 0; n < N; n++) begin
            path_d[n] = '0;
          end
          state_d = (len_clamp == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.obs_valid) begin
          delta_d   = acs_delta;
          bp_d[t_q] = acs_bp;
          t_d       = t_q + LW'(1);
          if (t_q == len_q - LW'(1)) begin
            state_d = TRACE;
          end
        end
      end
      TRACE: begin
        path_d[trace_idx] = trace_s;
        s_d               = trace_s;
        t_d               = trace_idx;
        if (trace_idx == '0) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      t_q     <= '0;
      s_q     <= '0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < I; i++) begin
        delta_q[i] <= '0;
      end
      for (int unsigned n = 0; n < N; n++) begin
        path_q[n] <= '0;
        for (int unsigned i = 0; i < I; i++) begin
          bp_q[n][i] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      t_q     <= t_d;
      s_q     <= s_d;
      done_q  <= done_d;
      delta_q <= delta_d;
      bp_q    <= bp_d;
      path_q  <= path_d;
    end
  end

  assign bus.path = path_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_viterbi_decoder.sv
module tb_viterbi_decoder;
  localparam int I = 3;
  localparam int K = 3;
  localparam int N = 5;
  localparam int W = 20;
  localparam int NV = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  viterbi_decoder_if #(.I(I), .K(K), .N(N), .W(W)) bus ();

  viterbi_decoder #(.I(I), .K(K), .N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    int              ps;        // 0 nominal, 1 cyclic, 2 all-zero
    int              len;
    logic [4:0][1:0] obs;
    int              stall_n;   // idle cycles before observation 2
    logic [4:0][1:0] path;
    bit              chk_delta;
    int              d0;
    int              d1;
    int              d2;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input int ps, len, o0, o1, o2, o3, o4, stall_n,
                              p0, p1, p2, p3, p4, chk, d0, d1, d2);
    vec_t r;
    r.ps = ps; r.len = len; r.stall_n = stall_n;
    r.obs[0] = 2'(o0); r.obs[1] = 2'(o1); r.obs[2] = 2'(o2);
    r.obs[3] = 2'(o3); r.obs[4] = 2'(o4);
    r.path[0] = 2'(p0); r.path[1] = 2'(p1); r.path[2] = 2'(p2);
    r.path[3] = 2'(p3); r.path[4] = 2'(p4);
    r.chk_delta = (chk != 0);
    r.d0 = d0; r.d1 = d1; r.d2 = d2;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_path_zero(input string name);
    for (int j = 0; j < N; j++) begin
      chk($sformatf("%s path[%0d]", name, j), int'(bus.path[j]), 0);
    end
  endtask

  task automatic load_params(input int ps);
    int nc [3]    = '{20, 18, 16};
    int na [3][3] = '{'{20, 10, 5}, '{10, 20, 5}, '{5, 10, 20}};
    int nb [3][3] = '{'{15, 10, 5}, '{10, 20, 5}, '{5, 15, 20}};
    for (int i = 0; i < I; i++) begin
      case (ps)
        0:       bus.logC[i] = W'(nc[i]);
        1:       bus.logC[i] = (i == 0) ? W'(0) : W'(-5);
        default: bus.logC[i] = W'(0);
      endcase
      for (int j = 0; j < I; j++) begin
        case (ps)
          0:       bus.logA[i][j] = W'(na[i][j]);
          1:       bus.logA[i][j] = (j == (i + 1) % 3) ? W'(0) : W'(-10);
          default: bus.logA[i][j] = W'(0);
        endcase
      end
      for (int k = 0; k < K; k++) begin
        case (ps)
          0:       bus.logB[i][k] = W'(nb[i][k]);
          1:       bus.logB[i][k] = (i == k) ? W'(0) : W'(-20);
          default: bus.logB[i][k] = W'(0);
        endcase
      end
    end
  endtask

  // Called at a negedge. The start cycle also carries a valid observation
  // that must not be consumed; stalls and the first trace cycle carry a
  // stray start that must be ignored.
  task automatic run_vec(input int vi);
    vec_t v;
    int   L;
    int   cyc;
    int   exp_cyc;
    int   dexp [3];
    v = vecs[vi];
    L = (v.len > N) ? N : v.len;
    load_params(v.ps);
    bus.start     = 1'b1;
    bus.length    = 3'(v.len);
    bus.obs_valid = 1'b1;
    bus.obs_in    = 2'd2;
    @(negedge clk);
    cyc = 1;
    bus.start     = 1'b0;
    bus.obs_valid = 1'b0;
    chk($sformatf("v%0d done_clr", vi), int'(bus.done), 0);
    chk_path_zero($sformatf("v%0d clr", vi));
    for (int t = 0; t < L; t++) begin
      if (t == 2) begin
        repeat (v.stall_n) begin
          bus.start     = 1'b1;
          bus.length    = 3'd1;
          bus.obs_valid = 1'b0;
          bus.obs_in    = 2'($urandom_range(0, 2));
          @(negedge clk);
          cyc++;
        end
      end
      bus.start     = 1'b0;
      bus.obs_valid = 1'b1;
      bus.obs_in    = v.obs[t];
      @(negedge clk);
      cyc++;
    end
    bus.obs_valid = 1'b0;
    if (L > 0) begin
      bus.start  = 1'b1;
      bus.length = 3'd1;
    end
    while (!bus.done && cyc < 64) begin
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
    end
    bus.start = 1'b0;
    exp_cyc = 2 * L + 2 + ((L > 2) ? v.stall_n : 0);
    chk($sformatf("v%0d done_rise", vi), int'(bus.done), 1);
    chk($sformatf("v%0d latency", vi), cyc, exp_cyc);
    for (int j = 0; j < N; j++) begin
      chk($sformatf("v%0d path[%0d]", vi, j), int'(bus.path[j]), int'(v.path[j]));
    end
    if (v.chk_delta) begin
      dexp = '{v.d0, v.d1, v.d2};
      for (int j = 0; j < I; j++) begin
        chk($sformatf("v%0d delta[%0d]", vi, j), int'($signed(dut.delta_q[j])), dexp[j]);
      end
    end
    repeat (3) begin
      bus.obs_valid = 1'b1;
      bus.obs_in    = 2'($urandom_range(0, 2));
      @(negedge clk);
    end
    bus.obs_valid = 1'b0;
    chk($sformatf("v%0d hold_done", vi), int'(bus.done), 1);
    for (int j = 0; j < N; j++) begin
      chk($sformatf("v%0d hold_path[%0d]", vi, j), int'(bus.path[j]), int'(v.path[j]));
    end
  endtask

  task automatic feed(input int o);
    bus.obs_valid = 1'b1;
    bus.obs_in    = 2'(o);
    @(negedge clk);
    bus.obs_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(0, 5, 0, 1, 2, 0, 1, 0, 1, 1, 1, 1, 1, 1, 155, 163, 156);
    vecs[1] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 35, 28, 21);
    vecs[2] = mk(2, 5, 2, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[3] = mk(0, 5, 0, 1, 2, 0, 1, 3, 1, 1, 1, 1, 1, 1, 155, 163, 156);
    vecs[4] = mk(1, 5, 0, 1, 2, 0, 1, 0, 0, 1, 2, 0, 1, 1, -30, 0, -30);
    vecs[5] = mk(1, 3, 0, 1, 2, 0, 0, 0, 0, 1, 2, 0, 0, 1, -30, -30, 0);
    vecs[6] = mk(1, 4, 0, 1, 2, 0, 0, 0, 0, 1, 2, 0, 0, 1, 0, -30, -30);
    vecs[7] = mk(0, 7, 0, 1, 2, 0, 1, 0, 1, 1, 1, 1, 1, 1, 155, 163, 156);
    vecs[8] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[9] = mk(1, 5, 0, 1, 2, 0, 1, 0, 0, 1, 2, 0, 1, 1, -30, 0, -30);

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.length    = '0;
    bus.obs_in    = '0;
    bus.obs_valid = 1'b0;
    load_params(0);
    repeat (3) @(negedge clk);
    chk("reset done", int'(bus.done), 0);
    chk_path_zero("reset");
    for (int j = 0; j < I; j++) begin
      chk($sformatf("reset delta[%0d]", j), int'($signed(dut.delta_q[j])), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int vi = 0; vi < NV; vi++) begin
      run_vec(vi);
    end

    // Reset during RUN: aborts, and the block stays idle afterwards.
    load_params(0);
    bus.start  = 1'b1;
    bus.length = 3'd5;
    @(negedge clk);
    bus.start = 1'b0;
    feed(0);
    feed(1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_run done", int'(bus.done), 0);
    chk_path_zero("rst_run");
    rst = 1'b0;
    repeat (12) feed(0);
    chk("rst_run idle done", int'(bus.done), 0);
    chk_path_zero("rst_run idle");

    // Reset during TRACE after path[4] and path[3] were written.
    bus.start  = 1'b1;
    bus.length = 3'd5;
    @(negedge clk);
    bus.start = 1'b0;
    feed(0); feed(1); feed(2); feed(0); feed(1);
    repeat (2) @(negedge clk);
    chk("mid_trace path[4]", int'(bus.path[4]), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_trace done", int'(bus.done), 0);
    chk_path_zero("rst_trace");
    @(negedge clk);

    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
